// File: rtl/rv32_alu_arbiter_if.sv
// Requester, response and ALU-side signals of rv32_alu_arbiter.
// The slave view belongs to the arbiter; the master view belongs to the requesters and the ALU.
interface rv32_alu_arbiter_if;
  logic [1:0]  i_req_valid;
  logic [1:0]  o_req_ready;
  logic [3:0]  i_req_sel;
  logic [63:0] i_req_op_a;
  logic [63:0] i_req_op_b;
  logic [1:0]  o_rsp_valid;
  logic [1:0]  i_rsp_ready;
  logic [31:0] o_rsp_result;
  logic        o_rsp_carry;
  logic        o_rsp_err;
  logic        o_alu_rst;
  logic        o_alu_en;
  logic [1:0]  o_alu_sel;
  logic [31:0] o_alu_operand_one;
  logic [31:0] o_alu_operand_two;
  logic        i_alu_data_valid;
  logic [31:0] i_alu_result;
  logic        i_alu_carry_out;

  modport slave (
    input  i_req_valid, i_req_sel, i_req_op_a, i_req_op_b, i_rsp_ready,
    input  i_alu_data_valid, i_alu_result, i_alu_carry_out,
    output o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_carry, o_rsp_err,
    output o_alu_rst, o_alu_en, o_alu_sel, o_alu_operand_one, o_alu_operand_two
  );

  modport master (
    output i_req_valid, i_req_sel, i_req_op_a, i_req_op_b, i_rsp_ready,
    output i_alu_data_valid, i_alu_result, i_alu_carry_out,
    input  o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_carry, o_rsp_err,
    input  o_alu_rst, o_alu_en, o_alu_sel, o_alu_operand_one, o_alu_operand_two
  );
endinterface

// File: rtl/rv32_alu_arbiter.sv
// Round-robin arbiter sharing one multicycle sliced ALU between the execute stage
// (requester 0) and address generation (requester 1), with a run timeout.
module rv32_alu_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input logic               i_clk,
  input logic               i_rst,
  rv32_alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_RESP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic        owner_q, owner_d;
  logic [1:0]  sel_q, sel_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] result_q, result_d;
  logic        carry_q, carry_d;
  logic        err_q, err_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic        alu_rst_q, alu_rst_d;
  logic        alu_en_q, alu_en_d;
  logic [1:0]  alu_sel_q, alu_sel_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;

  logic        grant;
  logic        drive_alu;

  // With both requesters pending the pointer decides; otherwise the lone requester wins.
  always_comb begin
    grant = (&bus.i_req_valid) ? rr_ptr_q : bus.i_req_valid[1];
    bus.o_req_ready = 2'b00;
    if (state_q == S_IDLE && |bus.i_req_valid)
      bus.o_req_ready = grant ? 2'b10 : 2'b01;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    sel_d    = sel_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    tmo_d    = tmo_q;
    result_d = result_q;
    carry_d  = carry_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (|bus.i_req_valid) begin
          owner_d  = grant;
          rr_ptr_d = ~grant;
          sel_d    = grant ? bus.i_req_sel[3:2]    : bus.i_req_sel[1:0];
          op_a_d   = grant ? bus.i_req_op_a[63:32] : bus.i_req_op_a[31:0];
          op_b_d   = grant ? bus.i_req_op_b[63:32] : bus.i_req_op_b[31:0];
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        tmo_d   = 8'd0;
        state_d = S_RUN;
      end
      S_RUN: begin
        tmo_d = tmo_q + 8'd1;
        // A result arriving on the final allowed cycle still beats the timeout.
        if (bus.i_alu_data_valid) begin
          result_d = bus.i_alu_result;
          carry_d  = bus.i_alu_carry_out;
          err_d    = 1'b0;
          state_d  = S_RESP;
        end else if (tmo_q == TMO_LAST) begin
          result_d = 32'd0;
          carry_d  = 1'b0;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.i_rsp_ready[owner_q])
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    drive_alu   = (state_d == S_CLEAR) || (state_d == S_RUN);
    alu_rst_d   = (state_d == S_CLEAR);
    alu_en_d    = (state_d == S_RUN);
    alu_sel_d   = drive_alu ? sel_d  : 2'b00;
    alu_a_d     = drive_alu ? op_a_d : 32'd0;
    alu_b_d     = drive_alu ? op_b_d : 32'd0;
    rsp_valid_d = (state_d == S_RESP) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 1'b0;
      owner_q     <= 1'b0;
      sel_q       <= 2'b00;
      op_a_q      <= 32'd0;
      op_b_q      <= 32'd0;
      tmo_q       <= 8'd0;
      result_q    <= 32'd0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 2'b00;
      alu_rst_q   <= 1'b0;
      alu_en_q    <= 1'b0;
      alu_sel_q   <= 2'b00;
      alu_a_q     <= 32'd0;
      alu_b_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      sel_q       <= sel_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      tmo_q       <= tmo_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      alu_rst_q   <= alu_rst_d;
      alu_en_q    <= alu_en_d;
      alu_sel_q   <= alu_sel_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
    end
  end

  assign bus.o_rsp_valid       = rsp_valid_q;
  assign bus.o_rsp_result      = result_q;
  assign bus.o_rsp_carry       = carry_q;
  assign bus.o_rsp_err         = err_q;
  assign bus.o_alu_rst         = alu_rst_q;
  assign bus.o_alu_en          = alu_en_q;
  assign bus.o_alu_sel         = alu_sel_q;
  assign bus.o_alu_operand_one = alu_a_q;
  assign bus.o_alu_operand_two = alu_b_q;
endmodule

// File: tb/tb_rv32_alu_arbiter.sv
// Directed bench for rv32_alu_arbiter with a two-phase 16-bit-sliced ALU model.
module tb_rv32_alu_arbiter;
  logic i_clk;
  logic i_rst;
  logic stall;
  int   vectors;
  int   miscompares;

  rv32_alu_arbiter_if bus ();

  rv32_alu_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Two-phase ALU: low half on phase 0, high half plus valid on phase 1.
  logic        alu_phase;
  logic [15:0] lo_res;
  logic        lo_c;
  logic [16:0] lo_calc;
  logic [16:0] hi_calc;

  function automatic logic [16:0] alu16(input logic [1:0] s, input logic [15:0] a,
                                        input logic [15:0] b, input logic ci);
    case (s)
      2'b00:   alu16 = {1'b0, a} + {1'b0, b} + {16'd0, ci};
      2'b01:   alu16 = {1'b0, a & b};
      2'b10:   alu16 = {1'b0, a | b};
      default: alu16 = {1'b0, a ^ b};
    endcase
  endfunction

  assign lo_calc = alu16(bus.o_alu_sel, bus.o_alu_operand_one[15:0], bus.o_alu_operand_two[15:0], 1'b0);
  assign hi_calc = alu16(bus.o_alu_sel, bus.o_alu_operand_one[31:16], bus.o_alu_operand_two[31:16], lo_c);
  assign bus.i_alu_data_valid = alu_phase && !stall;
  assign bus.i_alu_result     = {hi_calc[15:0], lo_res};
  assign bus.i_alu_carry_out  = hi_calc[16];

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      alu_phase <= 1'b0;
      lo_res    <= 16'd0;
      lo_c      <= 1'b0;
    end else if (bus.o_alu_rst) begin
      alu_phase <= 1'b0;
    end else if (bus.o_alu_en) begin
      alu_phase <= ~alu_phase;
      if (!alu_phase) begin
        lo_res <= lo_calc[15:0];
        lo_c   <= lo_calc[16];
      end
    end
  end

  task automatic set_req(input int r, input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
    if (r == 0) begin
      bus.i_req_sel[1:0]   = s;
      bus.i_req_op_a[31:0] = a;
      bus.i_req_op_b[31:0] = b;
    end else begin
      bus.i_req_sel[3:2]    = s;
      bus.i_req_op_a[63:32] = a;
      bus.i_req_op_b[63:32] = b;
    end
    bus.i_req_valid[r] = 1'b1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (bus.o_rsp_valid == 2'b00 && n < 40) begin
      @(negedge i_clk);
      n++;
    end
  endtask

  task automatic test_reset;
    logic [103:0] outs;
    i_rst = 1'b1;
    stall = 1'b0;
    bus.i_req_valid = 2'b00;
    bus.i_req_sel   = 4'd0;
    bus.i_req_op_a  = 64'd0;
    bus.i_req_op_b  = 64'd0;
    bus.i_rsp_ready = 2'b00;
    #12;
    outs = {bus.o_rsp_valid, bus.o_alu_rst, bus.o_alu_en, bus.o_alu_sel, bus.o_alu_operand_one,
            bus.o_alu_operand_two, bus.o_rsp_result, bus.o_rsp_carry, bus.o_rsp_err};
    vectors++;
    if (outs !== 104'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    vectors++;
    if (bus.o_req_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ready_idle: got %b expected 00", bus.o_req_ready);
    end
    bus.i_req_valid = 2'b01;
    #1;
    vectors++;
    if (bus.o_req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_ready_comb: got %b expected 01", bus.o_req_ready);
    end
    bus.i_req_valid = 2'b00;
    @(negedge i_clk);
    i_rst = 1'b0;
    $display("txn reset: outputs cleared");
  endtask

  task automatic test_single_add;
    int pulses;
    pulses = 0;
    @(negedge i_clk);
    bus.i_rsp_ready = 2'b01;
    set_req(0, 2'b00, 32'h0000FFFF, 32'h00000001);
    #1;
    vectors++;
    if (bus.o_req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL add_ready: got %b expected 01", bus.o_req_ready);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge i_clk);
      if (bus.o_alu_rst) pulses++;
      if (k == 1) begin
        bus.i_req_valid = 2'b00;
        vectors++;
        if ({bus.o_alu_rst, bus.o_alu_en} !== 2'b10) begin
          miscompares++;
          $display("FAIL add_clear_T1: rst/en got %b expected 10", {bus.o_alu_rst, bus.o_alu_en});
        end
      end
      if (k == 2 || k == 3) begin
        vectors++;
        if (bus.o_alu_en !== 1'b1) begin
          miscompares++;
          $display("FAIL add_run_en: cycle T+%0d got %b expected 1", k, bus.o_alu_en);
        end
      end
    end
    vectors++;
    if ({bus.o_rsp_valid, bus.o_rsp_result, bus.o_rsp_carry, bus.o_rsp_err} !== {2'b01, 32'h00010000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL add_rsp_T4: valid %b result %h carry %b err %b expected 01 00010000 0 0",
               bus.o_rsp_valid, bus.o_rsp_result, bus.o_rsp_carry, bus.o_rsp_err);
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL add_alu_rst_pulses: got %0d expected 1", pulses);
    end
    @(negedge i_clk);
    vectors++;
    if (bus.o_rsp_valid !== 2'b00) begin
      miscompares++;
      $display("FAIL add_rsp_drop: got %b expected 00", bus.o_rsp_valid);
    end
    $display("txn single_add: result %h", bus.o_rsp_result);
  endtask

  task automatic test_carry;
    int n;
    @(negedge i_clk);
    bus.i_rsp_ready = 2'b10;
    set_req(1, 2'b00, 32'hFFFFFFFF, 32'h00000001);
    @(negedge i_clk);
    bus.i_req_valid = 2'b00;
    wait_rsp(n);
    vectors++;
    if ({bus.o_rsp_valid, bus.o_rsp_result, bus.o_rsp_carry, bus.o_rsp_err} !== {2'b10, 32'h00000000, 1'b1, 1'b0} || n >= 40) begin
      miscompares++;
      $display("FAIL carry_rsp: valid %b result %h carry %b err %b expected 10 00000000 1 0",
               bus.o_rsp_valid, bus.o_rsp_result, bus.o_rsp_carry, bus.o_rsp_err);
    end
    @(negedge i_clk);
    $display("txn carry: result %h carry %b", bus.o_rsp_result, bus.o_rsp_carry);
  endtask

  task automatic test_round_robin;
    logic [1:0]  g [3];
    int          gc[3];
    logic [1:0]  ro[3];
    logic [31:0] rr[3];
    logic [1:0]  exp_g[3];
    logic [31:0] exp_r[3];
    int ng, nr;
    exp_g = '{2'b01, 2'b10, 2'b01};
    exp_r = '{32'h0F0FF0F0, 32'h00005678, 32'h0F0FF0F0};
    ng = 0;
    nr = 0;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    bus.i_rsp_ready = 2'b11;
    set_req(0, 2'b11, 32'hF0F0F0F0, 32'hFFFF0000);
    set_req(1, 2'b01, 32'h12345678, 32'h0000FFFF);
    for (int c = 0; c < 40 && nr < 3; c++) begin
      #1;
      if (bus.o_req_ready != 2'b00 && ng < 3) begin
        g[ng] = bus.o_req_ready;
        gc[ng] = c;
        ng++;
      end
      if (bus.o_rsp_valid != 2'b00) begin
        ro[nr] = bus.o_rsp_valid;
        rr[nr] = bus.o_rsp_result;
        nr++;
        if (nr == 3) bus.i_req_valid = 2'b00;
      end
      @(negedge i_clk);
    end
    bus.i_req_valid = 2'b00;
    vectors++;
    if (ng != 3 || nr != 3) begin
      miscompares++;
      $display("FAIL rr_count: grants %0d responses %0d expected 3 3", ng, nr);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (g[i] !== exp_g[i] || ro[i] !== exp_g[i] || rr[i] !== exp_r[i]) begin
          miscompares++;
          $display("FAIL rr_op%0d: grant %b owner %b result %h expected %b %b %h",
                   i, g[i], ro[i], rr[i], exp_g[i], exp_g[i], exp_r[i]);
        end
        $display("txn round_robin %0d: owner %b result %h", i, ro[i], rr[i]);
      end
      vectors++;
      if (gc[1] - gc[0] !== 5) begin
        miscompares++;
        $display("FAIL rr_back_to_back: accept spacing got %0d expected 5", gc[1] - gc[0]);
      end
    end
    @(negedge i_clk);
  endtask

  task automatic test_backpressure;
    int n;
    @(negedge i_clk);
    bus.i_rsp_ready = 2'b01;
    set_req(1, 2'b11, 32'h11111111, 32'h01010101);
    @(negedge i_clk);
    bus.i_req_valid = 2'b00;
    set_req(0, 2'b10, 32'h00FF0000, 32'h000000FF);
    wait_rsp(n);
    for (int k = 0; k < 6; k++) begin
      #1;
      vectors++;
      if ({bus.o_rsp_valid, bus.o_req_ready, bus.o_rsp_result, bus.o_rsp_carry, bus.o_rsp_err} !==
          {2'b10, 2'b00, 32'h10101010, 1'b0, 1'b0} || n >= 40) begin
        miscompares++;
        $display("FAIL bp_hold%0d: valid %b ready %b result %h carry %b expected 10 00 10101010 0",
                 k, bus.o_rsp_valid, bus.o_req_ready, bus.o_rsp_result, bus.o_rsp_carry);
      end
      @(negedge i_clk);
    end
    bus.i_rsp_ready = 2'b10;
    @(negedge i_clk);
    #1;
    vectors++;
    if ({bus.o_rsp_valid, bus.o_req_ready} !== {2'b00, 2'b01}) begin
      miscompares++;
      $display("FAIL bp_release: valid %b ready %b expected 00 01", bus.o_rsp_valid, bus.o_req_ready);
    end
    $display("txn backpressure: held result %h", 32'h10101010);
    @(negedge i_clk);
    bus.i_req_valid = 2'b00;
    bus.i_rsp_ready = 2'b01;
    wait_rsp(n);
    vectors++;
    if ({bus.o_rsp_valid, bus.o_rsp_result} !== {2'b01, 32'h00FF00FF}) begin
      miscompares++;
      $display("FAIL bp_next_op: valid %b result %h expected 01 00FF00FF", bus.o_rsp_valid, bus.o_rsp_result);
    end
    $display("txn backpressure follow-up: result %h", bus.o_rsp_result);
    @(negedge i_clk);
  endtask

  task automatic test_timeout;
    int n;
    int en_cnt;
    stall = 1'b1;
    en_cnt = 0;
    n = 0;
    @(negedge i_clk);
    bus.i_rsp_ready = 2'b01;
    set_req(0, 2'b00, 32'h00000005, 32'h00000007);
    @(negedge i_clk);
    bus.i_req_valid = 2'b00;
    while (bus.o_rsp_valid == 2'b00 && n < 40) begin
      if (bus.o_alu_en) en_cnt++;
      @(negedge i_clk);
      n++;
    end
    vectors++;
    if (en_cnt !== 8) begin
      miscompares++;
      $display("FAIL timeout_run_cycles: got %0d expected 8", en_cnt);
    end
    vectors++;
    if ({bus.o_rsp_valid, bus.o_rsp_result, bus.o_rsp_carry, bus.o_rsp_err} !== {2'b01, 32'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL timeout_rsp: valid %b result %h carry %b err %b expected 01 00000000 0 1",
               bus.o_rsp_valid, bus.o_rsp_result, bus.o_rsp_carry, bus.o_rsp_err);
    end
    $display("txn timeout: run cycles %0d err %b", en_cnt, bus.o_rsp_err);
    stall = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_reset_mid_op;
    int n;
    int seen;
    seen = 0;
    @(negedge i_clk);
    bus.i_rsp_ready = 2'b01;
    set_req(0, 2'b10, 32'hA0A0A0A0, 32'h0505050F);
    @(negedge i_clk);
    bus.i_req_valid = 2'b00;
    @(negedge i_clk);
    @(negedge i_clk);
    vectors++;
    if (bus.o_alu_en !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_run2: alu_en got %b expected 1", bus.o_alu_en);
    end
    #2;
    i_rst = 1'b1;
    #1;
    vectors++;
    if ({bus.o_alu_en, bus.o_rsp_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL midrst_async: en %b rsp_valid %b expected 0 00", bus.o_alu_en, bus.o_rsp_valid);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus.o_rsp_valid != 2'b00) seen++;
      @(negedge i_clk);
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL midrst_no_rsp: got %0d response cycles expected 0", seen);
    end
    set_req(0, 2'b10, 32'hA0A0A0A0, 32'h0505050F);
    #1;
    vectors++;
    if (bus.o_req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL midrst_reaccept: got %b expected 01", bus.o_req_ready);
    end
    @(negedge i_clk);
    bus.i_req_valid = 2'b00;
    wait_rsp(n);
    vectors++;
    if ({bus.o_rsp_valid, bus.o_rsp_result, bus.o_rsp_err} !== {2'b01, 32'hA5A5A5AF, 1'b0}) begin
      miscompares++;
      $display("FAIL midrst_or: valid %b result %h err %b expected 01 A5A5A5AF 0",
               bus.o_rsp_valid, bus.o_rsp_result, bus.o_rsp_err);
    end
    $display("txn reset_mid_op: follow-up result %h", bus.o_rsp_result);
    @(negedge i_clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_add();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/rv32_alu_arbiter.md
# rv32_alu_arbiter

Shares the single multicycle 16-bit-sliced ALU (`rv32_alu_fsm`) between two requesters: requester 0 is the execute stage and requester 1 is the address-generation path. Each op is accepted through a valid/ready handshake, with round-robin priority between the requesters. For each op the block clears the ALU's internal phase counter, drives enable until the ALU signals a valid result, latches that result, and returns it to the owning requester through a valid/ready response channel. A timeout guards against a stalled ALU.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 8. Maximum number of RUN cycles before the op is aborted with an error. Legal range is 2..255.

Ports:
- `i_clk`  in  1  Single clock. All logic is on the rising edge.
- `i_rst`  in  1  Reset. Asynchronous and active-high.
- `i_req_valid`  in  2  Per-requester request valid. Bit n belongs to requester n.
- `o_req_ready`  out  2  Per-requester accept. One-hot or zero.
- `i_req_sel`  in  4  ALU op per requester, 2 bits each: [1:0] for requester 0, [3:2] for requester 1. Encoding: 00 add, 01 and, 10 or, 11 xor.
- `i_req_op_a`  in  64  Operand A per requester: [31:0] for requester 0, [63:32] for requester 1.
- `i_req_op_b`  in  64  Operand B per requester, same packing as `i_req_op_a`.
- `o_rsp_valid`  out  2  Response valid, one-hot to the owner of the op.
- `i_rsp_ready`  in  2  Per-requester response accept.
- `o_rsp_result`  out  32  Latched result.
- `o_rsp_carry`  out  1  Latched carry from the upper half. Meaningful for add only.
- `o_rsp_err`  out  1  Op timed out. When set, result and carry are 0.
- `o_alu_rst`  out  1  Synchronous clear pulse to the ALU phase counter.
- `o_alu_en`  out  1  ALU phase-advance enable.
- `o_alu_sel`  out  2  Op select to the ALU.
- `o_alu_operand_one`  out  32  Operand A to the ALU.
- `o_alu_operand_two`  out  32  Operand B to the ALU.
- `i_alu_data_valid`  in  1  ALU result valid. Combinational from the ALU phase.
- `i_alu_result`  in  32  ALU result.
- `i_alu_carry_out`  in  1  ALU carry.

## Operation
- **State machine:** IDLE → CLEAR → RUN → RESP → IDLE.
- **IDLE**
  - `grant` = requester with `i_req_valid` set. If both are set, `grant` = `rr_ptr`.
  - `o_req_ready[grant]` = 1, combinationally. All other ready bits are 0.
  - On `valid & ready`: latch sel, op_a, op_b and the owner id; set `rr_ptr` to `~grant`; go to CLEAR.
- **CLEAR**
  - `o_alu_rst` = 1 and `o_alu_en` = 0 for exactly one cycle.
  - Go to RUN.
- **RUN**
  - `o_alu_en` = 1.
  - The timeout counter starts at 0 on entry and increments every RUN cycle.
  - If `i_alu_data_valid` = 1: latch `i_alu_result` and `i_alu_carry_out`, set `err` = 0, go to RESP.
  - Else, if the counter reaches `TIMEOUT_CYCLES`-1: latch result = 0, carry = 0, `err` = 1, go to RESP.
  - If both conditions hold in the same cycle, `data_valid` wins.
- **RESP**
  - `o_rsp_valid[owner]` = 1. Result, carry and err are held stable.
  - On `i_rsp_ready[owner]`: go to IDLE.
  - `i_rsp_ready` of the non-owner is ignored.
- **ALU drive:**
  - `o_alu_sel` and both operands come from the latched request registers in CLEAR and RUN.
  - In all other states they are 0.
- **No overlap:** only one op is in flight at a time. `o_req_ready` is 0 outside IDLE.
- **Requesters:** a requester may drop `i_req_valid` before it is accepted. Ungranted requests are not latched.

## Timing
- **Reset:** `i_rst` asynchronously forces:
  - state to IDLE and `rr_ptr` to 0;
  - timeout counter, latched request, result, carry and err to 0;
  - `o_rsp_valid`, `o_alu_rst`, `o_alu_en`, `o_alu_sel` and both ALU operands to 0.
- **`o_req_ready` during reset:** combinational from state and `i_req_valid`, so it is 0 unless `i_req_valid` is 1 and state is IDLE.
- **Reset mid-op:** an op in CLEAR, RUN or RESP is dropped with no response. The first cycle after deassertion is IDLE.
- **Nominal latency** (with the two-phase ALU):
  - accept edge at cycle T;
  - CLEAR in T+1;
  - RUN in T+2 (low half) and T+3 (`data_valid`, captured);
  - `o_rsp_valid` from T+4.
- **Back-to-back throughput:** with `i_rsp_ready` held high, RESP lasts one cycle, so the next accept is possible at T+5.
- **Response backpressure:** `o_rsp_valid` stays asserted for any number of cycles. Outputs do not change while waiting.
- **Outputs:** all outputs are registered, except `o_req_ready`, which is combinational in IDLE.

## Test plan
- **Single add:** requester 0, add, 0x0000FFFF + 0x00000001 with `i_rsp_ready`=1. Required: `o_rsp_valid`=2'b01 at T+4, result 0x00010000, carry 0, err 0, and exactly one `o_alu_rst` pulse at T+1.
- **Carry case:** requester 1, add, 0xFFFFFFFF + 0x00000001. Required: result 0x00000000, carry 1, `o_rsp_valid`=2'b10.
- **Round-robin:** both requesters hold valid continuously; requester 0 issues xor 0xF0F0F0F0^0xFFFF0000, requester 1 issues and 0x12345678&0x0000FFFF. Required:
  - grants alternate 0,1,0 (`rr_ptr` starts at 0);
  - results 0x0F0FF0F0 and 0x00005678, each to the correct owner.
- **Backpressure:** hold `i_rsp_ready`=0 for 6 cycles during RESP. Required: `o_rsp_valid`, result and carry stable throughout; `o_req_ready`=0 throughout; the next accept occurs only after the handshake.
- **Timeout:** tie `i_alu_data_valid`=0 with `TIMEOUT_CYCLES`=8. Required: exactly 8 RUN cycles with `o_alu_en`=1, then RESP with err=1 and result 0.
- **Reset mid-op:** assert `i_rst` asynchronously (between clock edges) in the second RUN cycle. Required: `o_alu_en` and `o_rsp_valid` go to 0 immediately, there is no response after release, and a subsequent or 0xA0A0A0A0|0x0505050F returns 0xA5A5A5AF.
